align_group_scheduler: RTL and testbench

- Sequences one shared partial-product alignment unit across a group of up to N partial products in the MAC subsystem.
- Collect phase: buffers each product (4-bit denorm_pp, 6-bit exp) and tracks the group maximum exponent.
- Issue phase: replays the buffer one entry per handshake into the aligner with the final max_exp and streams the 15-bit aligned results to the adder tree.
- Lets one aligner serve N products instead of N parallel aligners.

---
 rtl/align_pkg.sv | 11 +
 rtl/align_group_scheduler_max_exp_tracker.sv | 18 +
 rtl/align_group_scheduler.sv | 73 +++++++
 tb/tb_align_group_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/align_pkg.sv
// align_pkg: shared widths, buffer entry type and FSM states for the align group scheduler
package align_pkg;
  localparam int PP_W = 4;
  localparam int EXP_W = 6;
  localparam int ALIGN_W = 15;
  typedef struct packed {
    logic [PP_W-1:0]  denorm_pp;
    logic [EXP_W-1:0] exp;
  } pp_entry_t;
  typedef enum logic {COLLECT = 1'b0, ISSUE = 1'b1} state_e;
endpackage

// File: rtl/align_group_scheduler_max_exp_tracker.sv
// max_exp_tracker: running group maximum exponent, ignoring zero-magnitude products
module max_exp_tracker
  import align_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_upd,
  input  logic             i_clr,
  input  logic [PP_W-1:0]  i_denorm_pp,
  input  logic [EXP_W-1:0] i_exp,
  output logic [EXP_W-1:0] o_max_exp
);
  // raise the max only for nonzero magnitudes; clear when the group finishes issuing
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_max_exp <= '0;
    else if (i_clr) o_max_exp <= '0;
    else if (i_upd && |i_denorm_pp[2:0] && i_exp > o_max_exp) o_max_exp <= i_exp;
endmodule

// File: rtl/align_group_scheduler.sv
// align_group_scheduler: buffers a group of products, then replays them through one shared aligner
module align_group_scheduler
  import align_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [PP_W-1:0]    i_denorm_pp,
  input  logic [EXP_W-1:0]   i_exp,
  input  logic               i_last,
  output logic [PP_W-1:0]    o_al_denorm_pp,
  output logic [EXP_W-1:0]   o_al_exp,
  output logic [EXP_W-1:0]   o_al_max_exp,
  input  logic [ALIGN_W-1:0] i_al_align_pp,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [ALIGN_W-1:0] o_align_pp,
  output logic [IW-1:0]      o_idx,
  output logic               o_last,
  output logic [EXP_W-1:0]   o_max_exp
);
  state_e          state;
  logic [IW-1:0]   wr_idx, rd_idx, cnt;
  pp_entry_t       buf_q [N];
  logic [EXP_W-1:0] max_exp;
  logic            accept, issue_hs;
  assign o_ready        = state == COLLECT;
  assign o_valid        = state == ISSUE;
  assign accept         = o_ready && i_valid;
  assign issue_hs       = o_valid && i_ready;
  assign o_al_denorm_pp = buf_q[rd_idx].denorm_pp;
  assign o_al_exp       = buf_q[rd_idx].exp;
  assign o_al_max_exp   = max_exp;
  assign o_align_pp     = i_al_align_pp;
  assign o_idx          = rd_idx;
  assign o_last         = rd_idx == cnt;
  assign o_max_exp      = o_valid ? max_exp : '0;
  max_exp_tracker u_max (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_upd       (accept),
    .i_clr       (issue_hs && o_last),
    .i_denorm_pp (i_denorm_pp),
    .i_exp       (i_exp),
    .o_max_exp   (max_exp)
  );
  // collect products into the buffer, then walk the buffer one entry per downstream handshake
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state  <= COLLECT;
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else begin
      if (accept) begin
        buf_q[wr_idx] <= '{denorm_pp: i_denorm_pp, exp: i_exp};
        if (i_last || wr_idx == IW'(N - 1)) begin
          cnt    <= wr_idx;
          wr_idx <= '0;
          state  <= ISSUE;
        end else wr_idx <= wr_idx + 1'b1;
      end
      if (issue_hs) begin
        rd_idx <= o_last ? '0 : rd_idx + 1'b1;
        if (o_last) state <= COLLECT;
      end
    end
endmodule

// File: tb/tb_align_group_scheduler.sv
// tb_align_group_scheduler: directed scoreboard bench with a behavioural aligner model
module tb_align_group_scheduler;
  import align_pkg::*;
  localparam int N = 4;
  typedef struct {
    logic [14:0] pp;
    logic [1:0]  idx;
    logic        last;
    logic [5:0]  mx;
  } exp_t;
  logic        i_clk = 0, i_rst_n = 0, i_valid = 0, i_last = 0, i_ready = 1;
  logic [3:0]  i_denorm_pp = 0;
  logic [5:0]  i_exp = 0;
  logic        o_ready, o_valid, o_last;
  logic [3:0]  o_al_denorm_pp;
  logic [5:0]  o_al_exp, o_al_max_exp, o_max_exp;
  logic [14:0] i_al_align_pp, o_align_pp;
  logic [1:0]  o_idx;
  int          total = 0, bad = 0;
  exp_t        sb[$];
  logic [3:0]  g_pp[$];
  logic [5:0]  g_exp[$];
  logic [5:0]  mmax = 0;
  logic [14:0] obs[4];

  align_group_scheduler #(.N(N)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_denorm_pp(i_denorm_pp), .i_exp(i_exp), .i_last(i_last),
    .o_al_denorm_pp(o_al_denorm_pp), .o_al_exp(o_al_exp), .o_al_max_exp(o_al_max_exp),
    .i_al_align_pp(i_al_align_pp), .o_valid(o_valid), .i_ready(i_ready),
    .o_align_pp(o_align_pp), .o_idx(o_idx), .o_last(o_last), .o_max_exp(o_max_exp)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [14:0] align_f(input logic [3:0] pp, input logic [5:0] sh);
    logic [14:0] m;
    m = {12'd0, pp[2:0]} << 11;
    m = (sh > 6'd14) ? 15'd0 : m >> sh;
    return pp[3] ? (~m + 15'd1) : m;
  endfunction

  assign i_al_align_pp = align_f(o_al_denorm_pp, o_al_max_exp - o_al_exp);

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic send(input logic [3:0] pp, input logic [5:0] e, input logic l);
    i_valid = 1; i_denorm_pp = pp; i_exp = e; i_last = l;
    chk("in_ready", o_ready, 1);
    g_pp.push_back(pp);
    g_exp.push_back(e);
    if (pp[2:0] != 0 && e > mmax) mmax = e;
    if (l || g_pp.size() == N) begin
      foreach (g_pp[k])
        sb.push_back('{align_f(g_pp[k], mmax - g_exp[k]), 2'(k), k == g_pp.size() - 1, mmax});
      g_pp.delete();
      g_exp.delete();
      mmax = 0;
    end
    @(negedge i_clk);
    i_valid = 0; i_last = 0;
  endtask

  task automatic drain_one(input int stall);
    exp_t        e;
    int          t;
    logic [14:0] s_pp;
    logic [1:0]  s_idx;
    logic [15:0] s_al;
    t = 0;
    while (o_valid !== 1'b1 && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    chk("out_valid", o_valid, 1);
    if (stall > 0) begin
      i_ready = 0;
      s_pp = o_align_pp; s_idx = o_idx; s_al = {o_al_denorm_pp, o_al_exp, o_al_max_exp};
      repeat (stall) begin
        @(negedge i_clk);
        chk("bp_valid", o_valid, 1);
        chk("bp_pp", o_align_pp, s_pp);
        chk("bp_idx", o_idx, s_idx);
        chk("bp_al", {o_al_denorm_pp, o_al_exp, o_al_max_exp}, s_al);
      end
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL sb_underflow observed=result expected=none");
    end else begin
      e = sb.pop_front();
      chk("align_pp", o_align_pp, e.pp);
      chk("idx", o_idx, e.idx);
      chk("last", o_last, e.last);
      chk("max_exp", o_max_exp, e.mx);
      chk("al_max_exp", o_al_max_exp, e.mx);
      obs[o_idx] = o_align_pp;
    end
    i_ready = 1;
    @(negedge i_clk);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_max", o_max_exp, 0);
    chk("rst_idx", o_idx, 0);
    i_rst_n = 1;
    @(negedge i_clk);
    // group of four, max taken from the last product
    send(4'b0100, 10, 0); send(4'b0110, 12, 0); send(4'b0101, 7, 0); send(4'b0100, 20, 0);
    repeat (4) drain_one(0);
    chk("grp4_idx3", obs[3], 15'h2000);
    // single negative product
    send(4'b1100, 20, 1);
    drain_one(0);
    chk("neg_pp", obs[0], 15'h6000);
    chk("neg_ready_after", o_ready, 1);
    chk("neg_valid_after", o_valid, 0);
    // zero magnitude never raises the max
    send(4'b0000, 50, 0); send(4'b0100, 9, 1);
    repeat (2) drain_one(0);
    chk("zero_pp0", obs[0], 15'h0000);
    chk("zero_pp1", obs[1], 15'h2000);
    // backpressure on every result
    send(4'b0111, 3, 0); send(4'b1101, 8, 0); send(4'b0100, 1, 0); send(4'b0110, 6, 1);
    repeat (4) drain_one(3);
    // reset in the middle of issuing
    send(4'b0100, 40, 0); send(4'b0101, 30, 0); send(4'b0110, 35, 0); send(4'b0111, 20, 0);
    repeat (2) drain_one(0);
    #2 i_rst_n = 0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_al_max", o_al_max_exp, 0);
    chk("midrst_idx", o_idx, 0);
    sb.delete();
    @(negedge i_clk);
    i_rst_n = 1;
    send(4'b0100, 5, 0); send(4'b0110, 3, 1);
    repeat (2) drain_one(0);
    // short group closed by the third product
    send(4'b0101, 12, 0); send(4'b1110, 14, 0); send(4'b0100, 11, 1);
    repeat (3) drain_one(0);
    chk("short_ready_after", o_ready, 1);
    chk("short_valid_after", o_valid, 0);
    // all-zero group keeps max at zero
    send(4'b0000, 7, 0); send(4'b1000, 9, 0); send(4'b0000, 2, 0); send(4'b0000, 63, 1);
    repeat (4) drain_one(0);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
